// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one sprite from the sprite ROM into the frame buffer.
// The sprite is walked in ROM order (row-major). Transparent pixels (code 0)
// are skipped and pixels landing off-screen are clipped. Each visible pixel
// becomes one frame-buffer write transaction.
//
// Frame-buffer write handshake: fb_we is the valid. While fb_we=1, fb_addr and
// fb_data are held stable. A write completes on a rising edge where fb_we=1 and
// fb_ready=1. fb_we never drops before that edge, and at most one write is
// outstanding at any time.
module sprite_blitter #(
    parameter int SPR_W = 24,
    parameter int SPR_H = 45,
    parameter int FB_W  = 640,
    parameter int FB_H  = 480,
    parameter int PIX_W = 5
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [15:0]      spr_base,
    input  logic             hflip,
    output logic [15:0]      rom_addr,
    input  logic [PIX_W-1:0] rom_data,
    output logic [18:0]      fb_addr,
    output logic [PIX_W-1:0] fb_data,
    output logic             fb_we,
    input  logic             fb_ready,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbgState
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EVAL  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [9:0]       posXQ;
    logic [9:0]       posYQ;
    logic [15:0]      baseQ;
    logic             hflipQ;

    logic             accept;
    logic             advance;
    logic             loadWrite;
    logic             lastCol;
    logic             lastRow;
    logic [15:0]      rowOffset;
    logic [15:0]      colOffset;
    logic [10:0]      sx;
    logic [10:0]      sy;
    logic             pixVisible;
    logic [18:0]      pixAddr;

    // ROM address and screen coordinates, derived from the counters and latched inputs
    always_comb begin
        rowOffset  = 16'(row) * 16'(SPR_W);
        colOffset  = hflipQ ? (16'(SPR_W - 1) - 16'(col)) : 16'(col);
        rom_addr   = baseQ + rowOffset + colOffset;
        sx         = {1'b0, posXQ} + 11'(col);
        sy         = {1'b0, posYQ} + 11'(row);
        pixVisible = (rom_data != '0) && (sx < 11'(FB_W)) && (sy < 11'(FB_H));
        pixAddr    = 19'(sy) * 19'(FB_W) + 19'(sx);
        lastCol    = (col == COL_W'(SPR_W - 1));
        lastRow    = (row == ROW_W'(SPR_H - 1));
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        advance   = 1'b0;
        loadWrite = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    nextState = READ;
                end
            end
            READ: begin
                nextState = EVAL;
            end
            EVAL: begin
                if (pixVisible) begin
                    loadWrite = 1'b1;
                    nextState = WRITE;
                end else begin
                    advance   = 1'b1;
                    nextState = (lastCol && lastRow) ? DONE : READ;
                end
            end
            WRITE: begin
                if (fb_ready) begin
                    advance   = 1'b1;
                    nextState = (lastCol && lastRow) ? DONE : READ;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Latched draw parameters and the pixel counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            posXQ  <= '0;
            posYQ  <= '0;
            baseQ  <= '0;
            hflipQ <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else if (accept) begin
            posXQ  <= pos_x;
            posYQ  <= pos_y;
            baseQ  <= spr_base;
            hflipQ <= hflip;
            col    <= '0;
            row    <= '0;
        end else if (advance) begin
            if (!lastCol) begin
                col <= col + 1'b1;
            end else if (!lastRow) begin
                col <= '0;
                row <= row + 1'b1;
            end
        end
    end

    // Write transaction register: loaded in EVAL, held until accepted
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fb_addr <= '0;
            fb_data <= '0;
            fb_we   <= 1'b0;
        end else if (loadWrite) begin
            fb_addr <= pixAddr;
            fb_data <= rom_data;
            fb_we   <= 1'b1;
        end else if (state == WRITE && fb_ready) begin
            fb_we   <= 1'b0;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign dbgState = state;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: table-driven checks of sprite_blitter with a ROM model, a
// write scoreboard (expected writes queued at start, popped on each accepted
// write) and hand-written backpressure and mid-draw reset sequences.
`timescale 1ns/1ps
module tb_sprite_blitter;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [15:0] spr_base;
    logic        hflip;
    logic [15:0] rom_addr;
    logic [4:0]  rom_data;
    logic [18:0] fb_addr;
    logic [4:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        busy;
    logic        done;
    logic [2:0]  dbgState;

    sprite_blitter dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .spr_base (spr_base),
        .hflip    (hflip),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .fb_ready (fb_ready),
        .busy     (busy),
        .done     (done),
        .dbgState (dbgState)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- ROM model: one-cycle read latency ----------------
    logic [4:0] romMem [4096];
    always @(posedge Clk) rom_data <= romMem[rom_addr[11:0]];

    // ---------------- counters and scoreboard ----------------
    int          nChecks = 0;
    int          nFail   = 0;
    logic [23:0] expQ[$];
    int          writeCnt;
    int          firstAddr;
    int          firstData;
    int          lastAddr;
    int          stallBudget = 0;
    logic        holdValid = 1'b0;
    logic [18:0] holdAddr;
    logic [4:0]  holdData;

    task automatic check(input string name, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // fb_ready driver: normally 1, pulled low for stallBudget cycles of a pending write
    always @(posedge Clk) begin
        #1;
        if (stallBudget > 0 && fb_we) begin
            fb_ready = 1'b0;
            stallBudget--;
        end else begin
            fb_ready = 1'b1;
        end
    end

    // Write monitor: stall stability and scoreboard compare on each accepted write
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (holdValid) begin
                nChecks++;
                if (!fb_we || fb_addr != holdAddr || fb_data != holdData) begin
                    nFail++;
                    $display("FAIL stall_hold: got we=%0d addr=%0d data=%0d expected we=1 addr=%0d data=%0d",
                             fb_we, fb_addr, fb_data, holdAddr, holdData);
                end
            end
            holdValid = fb_we && !fb_ready;
            holdAddr  = fb_addr;
            holdData  = fb_data;
            if (fb_we && fb_ready) begin
                if (writeCnt == 0) begin
                    firstAddr = int'(fb_addr);
                    firstData = int'(fb_data);
                end
                lastAddr = int'(fb_addr);
                writeCnt++;
                nChecks++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL fb_write: got unexpected addr=%0d data=%0d expected no write", fb_addr, fb_data);
                end else begin
                    logic [23:0] e;
                    e = expQ.pop_front();
                    if (e != {fb_addr, fb_data}) begin
                        nFail++;
                        $display("FAIL fb_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 fb_addr, fb_data, e[23:5], e[4:0]);
                    end
                end
            end
        end
    end

    // Reference model: queue every write the sprite should produce
    task automatic push_expected(input int px, input int py, input int base, input bit hf);
        for (int r = 0; r < 45; r++) begin
            for (int c = 0; c < 24; c++) begin
                int idx;
                int sx;
                int sy;
                logic [4:0] pix;
                logic [18:0] a;
                idx = (base + r * 24 + (hf ? 23 - c : c)) & 16'hFFFF;
                pix = romMem[idx[11:0]];
                sx  = px + c;
                sy  = py + r;
                if (pix != 5'd0 && sx < 640 && sy < 480) begin
                    a = 19'(sy * 640 + sx);
                    expQ.push_back({a, pix});
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_draw(input int px, input int py, input int base, input bit hf);
        push_expected(px, py, base, hf);
        writeCnt = 0;
        @(posedge Clk); #1;
        pos_x    = 10'(px);
        pos_y    = 10'(py);
        spr_base = 16'(base);
        hflip    = hf;
        start    = 1'b1;
        @(posedge Clk); #1;
        start    = 1'b0;
    endtask

    task automatic finish_draw(input string name, input int expRom, input int expCycles,
                               input int expWrites, input int expFirstAddr,
                               input int expFirstData, input int expLastAddr, input bit poke);
        int  busyCycles;
        int  doneCnt;
        int  doneIdx;
        bit  ended;
        busyCycles = 0;
        doneCnt    = 0;
        doneIdx    = -10;
        ended      = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge Clk);
            if (i == 0) check({name, " first_rom_addr"}, int'(rom_addr), expRom);
            if (poke && i == 100) begin
                start = 1'b1;
                pos_x = 10'd300;
            end
            if (poke && i == 101) start = 1'b0;
            if (done) begin
                doneCnt++;
                doneIdx = i;
            end
            if (busy) begin
                busyCycles++;
            end else begin
                check({name, " busy_fall"}, i, doneIdx + 1);
                ended = 1'b1;
                break;
            end
        end
        check({name, " timeout"}, int'(ended), 1);
        check({name, " busy_cycles"}, busyCycles, expCycles);
        check({name, " done_pulses"}, doneCnt, 1);
        check({name, " write_count"}, writeCnt, expWrites);
        check({name, " missing_writes"}, expQ.size(), 0);
        check({name, " first_addr"}, firstAddr, expFirstAddr);
        check({name, " first_data"}, firstData, expFirstData);
        check({name, " last_addr"}, lastAddr, expLastAddr);
        expQ.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int px;
        int py;
        int base;
        bit hf;
        int expWrites;
        int expCycles;
        int expFirstAddr;
        int expFirstData;
        int expLastAddr;
    } vecT;

    vecT vecs[6];

    initial begin
        // sprites: 0 all-opaque(5), 1080 ramp (row 0 = 1..24), 2160 checkerboard 0/7
        for (int r = 0; r < 45; r++) begin
            for (int c = 0; c < 24; c++) begin
                romMem[r * 24 + c]        = 5'd5;
                romMem[1080 + r * 24 + c] = 5'(((r * 7 + c) % 31) + 1);
                romMem[2160 + r * 24 + c] = ((r + c) % 2 == 1) ? 5'd7 : 5'd0;
            end
        end
        for (int i = 3240; i < 4096; i++) romMem[i] = 5'd0;

        vecs[0] = '{0,   0,   0,    1'b0, 1080, 3241, 0,      5,  28183};
        vecs[1] = '{100, 50,  2160, 1'b0, 540,  2701, 32101,  7,  60283};
        vecs[2] = '{630, 470, 0,    1'b0, 100,  2261, 301430, 5,  307199};
        vecs[3] = '{200, 100, 1080, 1'b1, 1080, 3241, 64200,  24, 92383};
        vecs[4] = '{10,  300, 1080, 1'b0, 1080, 3241, 192010, 1,  220193};
        vecs[5] = '{620, 460, 2160, 1'b0, 200,  2361, 295021, 7,  307198};

        // ---------------- reset ----------------
        Reset_n  = 1'b0;
        start    = 1'b0;
        pos_x    = '0;
        pos_y    = '0;
        spr_base = '0;
        hflip    = 1'b0;
        writeCnt = 0;
        repeat (3) @(negedge Clk);
        check("reset fb_we", int'(fb_we), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset fb_addr", int'(fb_addr), 0);
        check("reset fb_data", int'(fb_data), 0);
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset state", int'(dbgState), 0);
        #2 Reset_n = 1'b1;

        // ---------------- table-driven draws ----------------
        for (int v = 0; v < 6; v++) begin
            start_draw(vecs[v].px, vecs[v].py, vecs[v].base, vecs[v].hf);
            finish_draw($sformatf("vec%0d", v), vecs[v].base + (vecs[v].hf ? 23 : 0),
                        vecs[v].expCycles, vecs[v].expWrites, vecs[v].expFirstAddr,
                        vecs[v].expFirstData, vecs[v].expLastAddr, 1'b0);
        end

        // ---------------- backpressure on the first write + start while busy ----------------
        stallBudget = 4;
        start_draw(0, 0, 0, 1'b0);
        finish_draw("stall", 0, 3245, 1080, 0, 5, 28183, 1'b1);

        // ---------------- reset during row 10 ----------------
        start_draw(0, 0, 0, 1'b0);
        begin
            bit reached;
            reached = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                @(negedge Clk);
                if (writeCnt >= 250) begin
                    reached = 1'b1;
                    break;
                end
            end
            check("midreset reached_row10", int'(reached), 1);
        end
        #2 Reset_n = 1'b0;
        #1;
        check("midreset fb_we", int'(fb_we), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset rom_addr", int'(rom_addr), 0);
        expQ.delete();
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        @(negedge Clk);
        check("after_reset busy", int'(busy), 0);
        check("after_reset done", int'(done), 0);
        start_draw(0, 0, 0, 1'b0);
        finish_draw("redraw", 0, 3241, 1080, 0, 5, 28183, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Writes one sprite from the sprite ROM into the pixel frame buffer at a given screen position. It works in the opposite direction to the scanline sprite reader: it walks the sprite in ROM order and issues frame-buffer write transactions, so the drawing engine can compose a frame into the back buffer of the dual frame buffer. Pixel code 0 is transparent and is skipped. Pixels that fall outside the screen are clipped.

## Interface
- SPR_W, 24, sprite width in pixels
- SPR_H, 45, sprite height in pixels
- FB_W, 640, frame buffer width
- FB_H, 480, frame buffer height
- PIX_W, 5, encoded pixel width
- Clk  in  1  single clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  draw request; sampled only in IDLE
- pos_x, pos_y  in  10 each  screen position of the sprite's top-left pixel; latched on accepted start
- spr_base  in  16  ROM word address of the sprite's pixel (0,0); latched on accepted start
- hflip  in  1  mirror horizontally; latched on accepted start
- rom_addr  out  16  sprite ROM address
- rom_data  in  PIX_W  ROM read data, valid one cycle after rom_addr is sampled
- fb_addr  out  19  frame-buffer word address = y*FB_W + x
- fb_data  out  PIX_W  pixel to write
- fb_we  out  1  write request; held until accepted
- fb_ready  in  1  a write completes on a rising edge with fb_we=1 and fb_ready=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sprite is finished

## Operation
- Internal state: col (0..SPR_W-1), row (0..SPR_H-1), the latched inputs, and the FSM.
- FSM states: IDLE, READ, EVAL, WRITE, DONE.
- IDLE:
  - If start=1: latch the inputs, set col=row=0, go to READ.
  - Otherwise stay in IDLE.
- READ: rom_addr = spr_base + row*SPR_W + (hflip ? SPR_W-1-col : col), combinational from the counters. Arithmetic is 16-bit and wraps modulo 2^16. Go to EVAL.
- EVAL: rom_data is valid.
  - sx = pos_x + col and sy = pos_y + row, computed at 11 bits so there is no overflow.
  - If rom_data != 0 and sx < FB_W and sy < FB_H: register fb_addr = sy*FB_W + sx and fb_data = rom_data, set fb_we=1, go to WRITE.
  - Otherwise advance the pixel with no write.
- WRITE: hold fb_we, fb_addr and fb_data stable until fb_ready=1. On acceptance, clear fb_we and advance.
- Advance:
  - If col < SPR_W-1: col+1, go to READ.
  - Else if row < SPR_H-1: col=0, row+1, go to READ.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start while not in IDLE is ignored; it is not queued. start in the cycle after DONE is accepted.
- Pixel order is row-major, top to bottom. Within each row, ROM order runs left to right; with hflip=1, the screen x order still ascends with col.

## Timing
- Reset (asynchronous, Reset_n=0) values:
  - State IDLE; col=row=0.
  - fb_we=0, busy=0, done=0.
  - fb_addr=0, fb_data=0.
  - Latched base=0, so rom_addr=0.
- Reset mid-draw: immediate return to the reset values. A pending write is dropped and done is not pulsed.
- busy rises in the cycle after the edge that accepts start, and falls in the cycle after DONE.
- Per-pixel cost with fb_ready held at 1:
  - Written pixel: 3 cycles (READ, EVAL, WRITE).
  - Skipped pixel: 2 cycles.
  - Each cycle of fb_ready=0 adds 1 cycle.
- Total cycles from accept to the done pulse = 2*SPR_W*SPR_H + (number of writes) + (stall cycles) + 1.
- At most one outstanding write; fb_we never asserts outside WRITE.

## Test plan
- All-opaque sprite (every code 5), pos (0,0), fb_ready=1, spr_base=0 -> 1080 writes, with fb_addr = r*640+c for r=0..44, c=0..23, fb_data=5. done pulses once, 3241 cycles after the accepting edge; busy falls one cycle later.
- Checkerboard sprite (0/7 alternating) at pos (100,50) -> exactly 540 writes, all with data 7 and none with 0. The first write is at 50*640+101 if pixel (0,0) is transparent.
- Clipping: all-opaque sprite at pos (630,470) -> exactly 100 writes (sx 630..639, sy 470..479). The last write is at fb_addr 307199, and done still pulses.
- hflip=1, spr_base=1080, ROM row 0 = 1..24 -> the screen row at pos_x gets 24, 23, ..., 1; rom_addr starts at 1103.
- Backpressure: fb_ready low for 4 cycles on the first write -> fb_we, fb_addr and fb_data are stable across the stall, and completion shifts by exactly 4 cycles. A start pulse during busy has no effect.
- Reset_n low for one cycle during row 10 -> fb_we=0 and busy=0 immediately with no done pulse. A new start then redraws from row 0 correctly.
